// File: rtl/fwd_stall_unit.sv
// Operand forwarding (byte-granular) and stall/flush control for the ID stage.
// Latency: forwarding, stall, enables and flush are combinational; MD scoreboard and stall counter are registered.
// Backpressure: id_exe_stall freezes PC/IR and bubbles EXE; flush overrides the PC hold for the exception vector.
module fwd_stall_unit #(
  parameter int NUM_RD  = 2,
  parameter int AW      = 5,
  parameter int BE      = 4,
  parameter int DIV_LAT = 33,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_RD-1:0]      rd_valid,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  input  logic [AW-1:0]          exe_waddr,
  input  logic [AW-1:0]          mem_waddr,
  input  logic [AW-1:0]          wb_waddr,
  input  logic [BE-1:0]          exe_wen,
  input  logic [BE-1:0]          mem_wen,
  input  logic [BE-1:0]          wb_wen,
  input  logic                   exe_load,
  input  logic                   mem_load,
  input  logic                   id_md_op,
  input  logic                   id_md_div,
  input  logic                   id_hilo_rd,
  input  logic                   exc_req,
  output logic [NUM_RD*BE*2-1:0] fwd_src,
  output logic                   id_exe_stall,
  output logic                   pc_we,
  output logic                   ir_we,
  output logic                   flush,
  output logic                   md_busy,
  output logic [31:0]            stall_cnt
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [1:0] SRC_RF  = 2'b00;
  localparam logic [1:0] SRC_EXE = 2'b01;
  localparam logic [1:0] SRC_MEM = 2'b10;
  localparam logic [1:0] SRC_WB  = 2'b11;

  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          armed_q, armed_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          load_haz;
  logic          md_haz;
  logic          md_issue;

  // Per-port, per-byte source select: nearest stage that actually writes this byte wins.
  always_comb begin
    fwd_src  = '0;
    load_haz = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int b = 0; b < BE; b++) begin
        logic       live;
        logic [1:0] src;
        live = rd_valid[p] && (rd_addr[p*AW +: AW] != '0);
        src  = SRC_RF;
        if (live && (exe_waddr == rd_addr[p*AW +: AW]) && exe_wen[b]) begin
          src = SRC_EXE;
          if (exe_load) load_haz = 1'b1;
        end else if (live && (mem_waddr == rd_addr[p*AW +: AW]) && mem_wen[b]) begin
          src = SRC_MEM;
          if (mem_load) load_haz = 1'b1;
        end else if (live && (wb_waddr == rd_addr[p*AW +: AW]) && wb_wen[b]) begin
          src = SRC_WB;
        end
        fwd_src[(p*BE+b)*2 +: 2] = src;
      end
    end
  end

  // Stall, flush and pipeline enables; flush forces the PC to take the exception vector.
  always_comb begin
    md_busy      = (md_cnt_q != '0);
    md_haz       = (id_md_op | id_hilo_rd) & md_busy;
    id_exe_stall = load_haz | md_haz;
    flush        = exc_req & armed_q;
    pc_we        = ~id_exe_stall | flush;
    ir_we        = ~(id_exe_stall | flush);
    stall_cnt    = stall_cnt_q;
  end

  // Next-state: MD occupancy counter, flush re-arm after exc_req drops, saturating stall counter.
  always_comb begin
    md_issue = id_md_op & ~id_exe_stall & ~flush;
    if (md_issue)
      md_cnt_d = id_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
    else
      md_cnt_d = md_cnt_q;

    if (flush)
      armed_d = 1'b0;
    else if (!exc_req)
      armed_d = 1'b1;
    else
      armed_d = armed_q;

    if (id_exe_stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    else
      stall_cnt_d = stall_cnt_q;
  end

  // State registers; the divider keeps running across a flush, so only reset clears the counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_cnt_q    <= '0;
      armed_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      armed_q     <= armed_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench for fwd_stall_unit: forwarding vector table plus MD, flush, reset and saturation sequences.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
// Stateful checks step whole clock cycles; the run ends with one summary line.
module tb_fwd_stall_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  rd_valid;
  logic [9:0]  rd_addr;
  logic [4:0]  exe_waddr, mem_waddr, wb_waddr;
  logic [3:0]  exe_wen, mem_wen, wb_wen;
  logic        exe_load, mem_load;
  logic        id_md_op, id_md_div, id_hilo_rd, exc_req;
  logic [15:0] fwd_src;
  logic        id_exe_stall, pc_we, ir_we, flush, md_busy;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_stall_unit #(.NUM_RD(2), .AW(5), .BE(4), .DIV_LAT(33), .MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .exe_waddr(exe_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .exe_wen(exe_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
    .exe_load(exe_load), .mem_load(mem_load),
    .id_md_op(id_md_op), .id_md_div(id_md_div), .id_hilo_rd(id_hilo_rd),
    .exc_req(exc_req),
    .fwd_src(fwd_src), .id_exe_stall(id_exe_stall), .pc_we(pc_we), .ir_we(ir_we),
    .flush(flush), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    logic [9:0]  ra;
    logic [4:0]  ea, ma, wa;
    logic [3:0]  ew, mw, ww;
    logic        el, ml;
    logic [15:0] efwd;
    logic        estall;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_valid = '0; rd_addr = '0;
    exe_waddr = '0; mem_waddr = '0; wb_waddr = '0;
    exe_wen = '0; mem_wen = '0; wb_wen = '0;
    exe_load = 0; mem_load = 0;
    id_md_op = 0; id_md_div = 0; id_hilo_rd = 0; exc_req = 0;
  endtask

  // Port1 reads r3 while EXE holds a full-word load to r3.
  task automatic load_hazard_inputs();
    idle_inputs();
    rd_valid = 2'b10; rd_addr = {5'd3, 5'd0};
    exe_waddr = 5'd3; exe_wen = 4'b1111; exe_load = 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 0;
    #2;
    resetn = 1;
    #1;
  endtask

  // Issue an MD op at ID, then hold MFHI and track busy/stall for lat cycles plus the release.
  task automatic md_seq(input logic is_div, input int lat);
    idle_inputs();
    id_md_op = 1; id_md_div = is_div;
    #1;
    chk("md_issue_nostall", {31'd0, id_exe_stall}, 32'd0);
    cyc();
    id_md_op = 0; id_md_div = 0; id_hilo_rd = 1;
    #1;
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("md_busy_t+%0d", k), {31'd0, md_busy}, 32'd1);
      chk($sformatf("md_stall_t+%0d", k), {31'd0, id_exe_stall}, 32'd1);
      cyc();
    end
    chk("md_busy_release", {31'd0, md_busy}, 32'd0);
    chk("md_stall_release", {31'd0, id_exe_stall}, 32'd0);
    chk("md_irwe_release", {31'd0, ir_we}, 32'd1);
    idle_inputs();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                 rv     ra                 ea     ma     wa     ew       mw       ww       el ml efwd      stall
    vecs[0] = '{2'b01, {5'd0, 5'd8},  5'd8,  5'd8,  5'd0,  4'b0011, 4'b1111, 4'b0000, 0, 0, 16'h00A5, 0}; // byte merge
    vecs[1] = '{2'b10, {5'd3, 5'd0},  5'd3,  5'd0,  5'd0,  4'b1111, 4'b0000, 4'b0000, 1, 0, 16'h5500, 1}; // load in EXE
    vecs[2] = '{2'b10, {5'd3, 5'd0},  5'd0,  5'd3,  5'd0,  4'b0000, 4'b1111, 4'b0000, 0, 1, 16'hAA00, 1}; // load in MEM
    vecs[3] = '{2'b10, {5'd3, 5'd0},  5'd0,  5'd0,  5'd3,  4'b0000, 4'b0000, 4'b1111, 0, 0, 16'hFF00, 0}; // load in WB
    vecs[4] = '{2'b11, {5'd0, 5'd0},  5'd0,  5'd0,  5'd0,  4'b1111, 4'b1111, 4'b1111, 1, 1, 16'h0000, 0}; // r0
    vecs[5] = '{2'b00, {5'd3, 5'd3},  5'd3,  5'd3,  5'd3,  4'b1111, 4'b1111, 4'b1111, 1, 1, 16'h0000, 0}; // unread
    vecs[6] = '{2'b01, {5'd0, 5'd5},  5'd5,  5'd5,  5'd5,  4'b0000, 4'b1111, 4'b1111, 0, 1, 16'h00AA, 1}; // no shadow
    vecs[7] = '{2'b11, {5'd6, 5'd5},  5'd6,  5'd5,  5'd5,  4'b1000, 4'b0001, 4'b1110, 0, 0, 16'h40FE, 0}; // mixed
    vecs[8] = '{2'b11, {5'd7, 5'd7},  5'd7,  5'd0,  5'd0,  4'b0100, 4'b0000, 4'b0000, 1, 0, 16'h1010, 1}; // byte load

    idle_inputs();
    resetn = 0;
    #3;
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pc_we", {31'd0, pc_we}, 32'd1);
    @(negedge clk);
    resetn = 1;

    // Combinational forwarding table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle_inputs();
      rd_valid = vecs[i].rv; rd_addr = vecs[i].ra;
      exe_waddr = vecs[i].ea; mem_waddr = vecs[i].ma; wb_waddr = vecs[i].wa;
      exe_wen = vecs[i].ew; mem_wen = vecs[i].mw; wb_wen = vecs[i].ww;
      exe_load = vecs[i].el; mem_load = vecs[i].ml;
      #1;
      chk($sformatf("vec%0d_fwd", i), {16'd0, fwd_src}, {16'd0, vecs[i].efwd});
      chk($sformatf("vec%0d_stall", i), {31'd0, id_exe_stall}, {31'd0, vecs[i].estall});
      chk($sformatf("vec%0d_pc_we", i), {31'd0, pc_we}, {31'd0, ~vecs[i].estall});
      chk($sformatf("vec%0d_ir_we", i), {31'd0, ir_we}, {31'd0, ~vecs[i].estall});
    end

    pulse_reset();
    @(negedge clk);
    md_seq(1'b1, 33);
    md_seq(1'b0, 2);

    // Exception held 5 cycles during a load hazard: one flush pulse only.
    @(negedge clk);
    load_hazard_inputs();
    exc_req = 1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("exc_flush_c%0d", k), {31'd0, flush}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("exc_pc_we_c%0d", k), {31'd0, pc_we}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("exc_ir_we_c%0d", k), {31'd0, ir_we}, 32'd0);
      chk($sformatf("exc_stall_c%0d", k), {31'd0, id_exe_stall}, 32'd1);
      cyc();
    end
    exc_req = 0;
    #1;
    chk("exc_low_flush", {31'd0, flush}, 32'd0);
    cyc();
    exc_req = 1;
    #1;
    chk("exc_second_flush", {31'd0, flush}, 32'd1);
    cyc();
    chk("exc_second_oneshot", {31'd0, flush}, 32'd0);
    exc_req = 0;
    cyc();

    // MD issue coinciding with a flush is dropped.
    idle_inputs();
    id_md_op = 1; id_md_div = 1; exc_req = 1;
    #1;
    chk("md_flush_pulse", {31'd0, flush}, 32'd1);
    cyc();
    idle_inputs();
    #1;
    chk("md_flush_not_issued", {31'd0, md_busy}, 32'd0);

    // Asynchronous reset in the middle of a divide.
    cyc();
    id_md_op = 1; id_md_div = 1;
    cyc();
    id_md_op = 0; id_md_div = 0; id_hilo_rd = 1;
    cyc(); cyc(); cyc();
    chk("mid_div_busy", {31'd0, md_busy}, 32'd1);
    @(posedge clk);
    #3;
    resetn = 0;
    #1;
    chk("async_rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("async_rst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    resetn = 1;
    idle_inputs();

    // Saturation from a forced near-max stall count.
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    load_hazard_inputs();
    #1;
    chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("sat_cycle%0d", k), stall_cnt, 32'hFFFF_FFFF);
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_stall_unit.md
# fwd_stall_unit

Parametrised operand-forwarding and stall controller for the 5-stage MIPS pipeline. It is the generalised successor of the current bypass logic:
- any number of ID read ports;
- byte-granular forwarding, so partial-word writers (LWL/LWR, byte-enable ALU writes) merge correctly with older producers;
- a latency-tracking scoreboard for the multi-cycle MUL/DIV unit;
- a one-shot exception flush and a saturating stall-cycle counter.

It sits beside the ID stage and drives the PC/IR enables, the ID/EXE bubble and the per-byte operand muxes.

## Interface
- NUM_RD, 2, number of ID register read ports
- AW, 5, register address width
- BE, 4, byte enables per register (data width = 8*BE)
- DIV_LAT, 33, cycles the divider occupies HI/LO
- MUL_LAT, 2, cycles the multiplier occupies HI/LO
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- rd_valid  in  NUM_RD  port p actually reads its register
- rd_addr  in  NUM_RD*AW  read address of port p at bits [p*AW +: AW]
- exe_waddr / mem_waddr / wb_waddr  in  AW each  destination register per stage
- exe_wen / mem_wen / wb_wen  in  BE each  byte write enables per stage
- exe_load / mem_load  in  1 each  producer in that stage is a load
- id_md_op  in  1  ID instruction is MULT/DIV(U)
- id_md_div  in  1  that op is a divide
- id_hilo_rd  in  1  ID instruction reads HI/LO (MFHI/MFLO)
- exc_req  in  1  exception/trap request, level
- fwd_src  out  NUM_RD*BE*2  per port, per byte source at [(p*BE+b)*2 +: 2]: 00 regfile, 01 EXE, 10 MEM, 11 WB
- id_exe_stall  out  1  hold ID, insert bubble into EXE
- pc_we  out  1  PC write enable
- ir_we  out  1  IF/ID register write enable
- flush  out  1  one-cycle exception flush
- md_busy  out  1  HI/LO result still pending
- stall_cnt  out  32  saturating count of stalled cycles

## Operation
- **Byte match.** Byte b of port p matches stage S when all of these hold:
  - rd_valid[p] is set;
  - rd_addr[p] is non-zero;
  - S_waddr equals rd_addr[p];
  - S_wen[b] is set.
- **Source priority.** Per byte, the source is the nearest matching stage in the order EXE, MEM, WB, otherwise the regfile.
  - A closer stage with S_wen[b]=0 does not shadow an older stage for byte b.
- **Load hazard.** It is asserted when any byte of any port selects EXE while exe_load=1, or selects MEM while mem_load=1. Load data is forwardable only from WB.
- **MD counter.** It is an internal counter wide enough for max(DIV_LAT, MUL_LAT).
  - Loads DIV_LAT or MUL_LAT (chosen by id_md_div) when id_md_op & ~id_exe_stall & ~flush.
  - Otherwise it decrements while non-zero.
  - md_busy = (counter != 0).
  - flush does not clear the counter, because the divider keeps running.
- **MD hazard.** It is asserted when (id_md_op | id_hilo_rd) & md_busy.
- **Stall output.** id_exe_stall = load hazard | MD hazard.
- **Flush.** An internal armed flag drives it.
  - flush = exc_req & armed.
  - armed clears on the cycle after flush and re-sets only after exc_req has been sampled low.
  - A level exc_req held N cycles therefore gives exactly one flush pulse.
- **Enables.**
  - pc_we = ~id_exe_stall | flush; a flush loads the exception vector even while stalled.
  - ir_we = ~(id_exe_stall | flush).
- **Stall counter.** stall_cnt increments on every cycle with id_exe_stall=1 and saturates at 32'hFFFF_FFFF.

## Timing
- fwd_src, id_exe_stall, pc_we, ir_we and flush are combinational from the current-cycle inputs and state; there are no added cycles.
- md_busy rises the cycle after the accepted MD issue. It stays high for exactly LAT cycles, then falls.
- A dependent MFHI is released on the first cycle md_busy=0.
- **Reset** (asynchronous, resetn low):
  - counter=0, md_busy=0;
  - armed=1;
  - stall_cnt=0.
- Combinational outputs follow inputs during reset; the bench holds exc_req=0 while in reset.
- Reset asserted mid-divide clears md_busy immediately, without waiting for a clock edge.
- **Simultaneous events:**
  - load hazard and flush in the same cycle: flush wins for ir_we=0, pc_we=1;
  - MD issue during flush is not accepted.

## Test plan
- **Byte merge.**
  - Stimulus: port0 reads r8; EXE writes r8 with wen=0011; MEM writes r8 with wen=1111; no loads.
  - Required: port0 byte sources 01,01,10,10, i.e. fwd_src[7:0]=8'b10100101; no stall.
- **Load-use.**
  - Stimulus: port1 reads r3; EXE is a load to r3 with wen=1111.
  - Required: id_exe_stall=1, pc_we=0, ir_we=0.
  - Next cycle, the load moves to MEM with mem_load=1: stall stays 1.
  - Following cycle, the load is in WB: stall=0 and all four port1 bytes select 11.
- **r0 and unread ports.**
  - Stimulus: rd_addr=0 with all stages writing r0; separately, rd_valid=0 with an address match.
  - Required: fwd_src=00 and no stall in both cases.
- **Divide scoreboard.**
  - Stimulus: issue DIV at cycle t; present MFHI at ID from t+1.
  - Required: md_busy high t+1..t+33; stall high through t+33; released at t+34.
  - Repeat with MULT: busy for exactly 2 cycles.
- **Exception one-shot.**
  - Stimulus: hold exc_req high for 5 cycles while a load hazard is present.
  - Required: flush=1 only in the first cycle, with pc_we=1 and ir_we=0 in that cycle.
  - Drop exc_req for 1 cycle, then raise it again: a second single flush pulse.
- **Reset and saturation.**
  - Stimulus: assert resetn=0 asynchronously mid-divide.
  - Required: md_busy=0 and stall_cnt=0 without waiting for a clock edge.
  - Stimulus: preload stall_cnt to 32'hFFFF_FFFE via a forced state and stall 3 cycles.
  - Required: stall_cnt holds at 32'hFFFF_FFFF.
